seq_mult_shift_add: RTL and testbench

//   Parametrised sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product, unsigned or
//   two's-complement selected per operation. Successor to the fixed 4-bit multiplier: adds width

---
 rtl/seq_mult_shift_add_pkg.sv | 25 ++
 rtl/mult_sign_adapter.sv | 27 ++
 rtl/seq_mult_shift_add.sv | 137 +++++++++++++
 tb/tb_seq_mult_shift_add.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_shift_add_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_t      : controller states IDLE -> BUSY -> DONE -> IDLE
//   cnt_width()  : iteration counter width for a given operand width
//   prod_width() : product width for a given operand width
package seq_mult_shift_add_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter only has to hold 0..w-1, so clog2(w) bits are enough.
  // The floor of 1 keeps the counter at least one bit wide.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/mult_sign_adapter.sv
// Conditional two's-complement negate, used for two jobs:
//   - on an input operand, it turns a signed operand into its magnitude
//     (negate = is_signed & msb);
//   - on the result, it applies the final sign to the unsigned product.
// The most negative operand -2^(W-1) maps to itself. Read as unsigned,
// that bit pattern is exactly the magnitude 2^(W-1), so no extra bit is
// needed.
// Ports:
//   value  in  W  operand
//   negate in  1  1 = return -value, 0 = pass value through
//   result out W  value or its two's complement
module mult_sign_adapter #(
  parameter int W = 4
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  always_comb begin
    result = value;
    if (negate) begin
      result = W'(0) - value;
    end
  end

endmodule

// File: rtl/seq_mult_shift_add.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH.
// Operands are unsigned or two's complement; the mode is chosen for each
// operation. The core multiplies unsigned magnitudes over exactly WIDTH
// cycles and applies the sign when it loads the product.
// Only one operation is in flight at a time.
// Ports:
//   clk        in   1          rising-edge clock
//   reset      in   1          asynchronous, active-low reset
//   in_valid   in   1          A, B and is_signed are valid
//   in_ready   out  1          operands can be accepted (IDLE only)
//   A          in   WIDTH      multiplicand
//   B          in   WIDTH      multiplier
//   is_signed  in   1          1 = two's complement operands
//   out_valid  out  1          product valid, held until out_ready
//   out_ready  in   1          consumer takes the product
//   product    out  2*WIDTH    result, held until the next result loads
module seq_mult_shift_add
  import seq_mult_shift_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W  = cnt_width(WIDTH);
  localparam int PROD_W = prod_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   mcand;     // multiplicand magnitude
  logic [WIDTH-1:0]   mplr;      // multiplier, shifted out LSB-first
  logic [WIDTH-1:0]   acc;       // upper half of the running product
  logic               sign_neg;  // result must be negated

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   acc_next;
  logic [WIDTH-1:0]   mplr_next;
  logic [PROD_W-1:0]  prod_mag;
  logic [PROD_W-1:0]  prod_final;

  mult_sign_adapter #(.W(WIDTH)) u_a_mag (
    .value  (A),
    .negate (is_signed & A[WIDTH-1]),
    .result (a_mag)
  );

  mult_sign_adapter #(.W(WIDTH)) u_b_mag (
    .value  (B),
    .negate (is_signed & B[WIDTH-1]),
    .result (b_mag)
  );

  // One shift-add step. The carry out of the WIDTH+1-bit sum becomes the
  // new top bit of acc. The bit leaving acc enters the top of mplr as the
  // multiplier's own LSB is shifted out. After WIDTH steps, {acc, mplr}
  // holds the full unsigned product.
  always_comb begin
    addend    = mplr[0] ? mcand : '0;
    sum       = {1'b0, acc} + {1'b0, addend};
    acc_next  = sum[WIDTH:1];
    mplr_next = {sum[0], mplr[WIDTH-1:1]};
    prod_mag  = {acc_next, mplr_next};
  end

  // The final step's result is negated on the way into the product
  // register. This puts out_valid exactly WIDTH edges after accept.
  mult_sign_adapter #(.W(PROD_W)) u_prod_sign (
    .value  (prod_mag),
    .negate (sign_neg),
    .result (prod_final)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= '0;
      count     <= '0;
      mcand     <= '0;
      mplr      <= '0;
      acc       <= '0;
      sign_neg  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mcand    <= a_mag;
            mplr     <= b_mag;
            acc      <= '0;
            count    <= '0;
            sign_neg <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc   <= acc_next;
          mplr  <= mplr_next;
          count <= count + CNT_ONE;
          if (count == CNT_LAST) begin
            product   <= prod_final;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Directed bench for seq_mult_shift_add at WIDTH=4, plus a WIDTH=8
// random sweep in signed and unsigned mode. Both instances share the
// clock and reset. Inputs are driven and outputs sampled on the falling
// clock edge.
module tb_seq_mult_shift_add;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // WIDTH=4 instance
  logic       iv4, ir4, s4, ov4, or4;
  logic [3:0] a4, b4;
  logic [7:0] p4;

  // WIDTH=8 instance
  logic        iv8, ir8, s8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  seq_mult_shift_add #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (iv4),
    .in_ready  (ir4),
    .A         (a4),
    .B         (b4),
    .is_signed (s4),
    .out_valid (ov4),
    .out_ready (or4),
    .product   (p4)
  );

  seq_mult_shift_add #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .A         (a8),
    .B         (b8),
    .is_signed (s8),
    .out_valid (ov8),
    .out_ready (or8),
    .product   (p8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge. Returns the product and the number of
  // rising edges from the accepting edge to the first out_valid.
  // The result is left pending in DONE.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s,
                     output logic [7:0] p, output int lat);
    int n;
    a4 = a; b4 = b; s4 = s; iv4 = 1'b1;
    n = 0;
    while (!ir4 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    iv4 = 1'b0;
    lat = 0;
    while (!ov4 && lat < 50) begin @(negedge clk); lat++; end
    p = p4;
  endtask

  task automatic rel4();
    or4 = 1'b1;
    @(negedge clk);
    or4 = 1'b0;
  endtask

  // Full WIDTH=8 transaction, including the output handshake.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     output logic [15:0] p, output int lat);
    int n;
    a8 = a; b8 = b; s8 = s; iv8 = 1'b1;
    n = 0;
    while (!ir8 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 50) begin @(negedge clk); lat++; end
    p = p8;
    or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic signed [7:0] sa, sb;
    int r;
    sa = a; sb = b;
    if (s) r = int'(sa) * int'(sb);
    else   r = int'(a) * int'(b);
    return r[15:0];
  endfunction

  logic [7:0]  p;
  logic [15:0] pw;
  int          lat;
  logic [3:0]  ta  [4] = '{4'd0, 4'd3, 4'd15, 4'd5};
  logic [3:0]  tbv [4] = '{4'd13, 4'd4, 4'd1, 4'd5};
  logic [7:0]  te  [4] = '{8'd0, 8'd12, 8'd15, 8'd25};
  int          acc_cyc [4];
  logic [7:0]  ra, rb;

  initial begin
    reset = 1'b1;
    iv4 = 1'b0; s4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0;
    iv8 = 1'b0; s8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", ov4, 1'b0);
    check("rst_product", p4, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_in_ready", ir4, 1'b1);

    // Unsigned maximum operands, fixed latency.
    op4(4'd15, 4'd15, 1'b0, p, lat);
    check("u15x15", p, 8'hE1);
    check("u15x15_lat", lat, 4);
    rel4();
    check("u15x15_ov_drop", ov4, 1'b0);
    check("u15x15_ir_back", ir4, 1'b1);

    // Signed cases, including most-negative times most-negative.
    op4(4'hD, 4'd5, 1'b1, p, lat);
    check("s_m3x5", p, 8'hF1);
    check("s_m3x5_lat", lat, 4);
    rel4();
    op4(4'h8, 4'h8, 1'b1, p, lat);
    check("s_m8xm8", p, 8'h40);
    rel4();
    op4(4'h8, 4'h7, 1'b1, p, lat);
    check("s_m8x7", p, 8'hC8);
    rel4();
    op4(4'h8, 4'h8, 1'b0, p, lat);
    check("u_8x8", p, 8'h40);
    rel4();

    // Backpressure: DONE held for 10 cycles, new operands must be ignored.
    op4(4'd6, 4'hE, 1'b1, p, lat);
    check("bp_prod", p, 8'hF4);
    a4 = 4'd1; b4 = 4'd1; s4 = 1'b0; iv4 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", ov4, 1'b1);
      check("bp_product", p4, 8'hF4);
      check("bp_in_ready", ir4, 1'b0);
    end
    iv4 = 1'b0;
    rel4();
    check("bp_released", ov4, 1'b0);
    check("bp_product_held", p4, 8'hF4);

    // Reset two cycles into an operation.
    a4 = 4'd7; b4 = 4'd9; s4 = 1'b0; iv4 = 1'b1;
    @(negedge clk);
    iv4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rstmid_out_valid", ov4, 1'b0);
    check("rstmid_product", p4, 8'h00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) @(negedge clk);
    check("rstmid_no_result", ov4, 1'b0);
    check("rstmid_in_ready", ir4, 1'b1);
    op4(4'd2, 4'd3, 1'b0, p, lat);
    check("after_rst_2x3", p, 8'h06);
    check("after_rst_lat", lat, 4);
    rel4();

    // Back-to-back with the consumer always ready.
    begin
      int k, r, cyc;
      k = 0; r = 0; cyc = 0;
      or4 = 1'b1; s4 = 1'b0;
      while ((k < 4 || r < 4) && cyc < 100) begin
        if (k < 4) begin a4 = ta[k]; b4 = tbv[k]; iv4 = 1'b1; end
        else iv4 = 1'b0;
        if (ov4 && r < 4) begin check("b2b_prod", p4, te[r]); r++; end
        if (ir4 && iv4) begin acc_cyc[k] = cyc; k++; end
        @(negedge clk);
        cyc++;
      end
      iv4 = 1'b0; or4 = 1'b0;
      check("b2b_results", r, 4);
      check("b2b_accepts", k, 4);
      for (int i = 1; i < 4; i++) check("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 6);
    end

    // WIDTH=8: boundary operands, then random sweeps in both modes.
    op8(8'h80, 8'h80, 1'b1, pw, lat);
    check("w8_m128xm128", pw, 16'h4000);
    check("w8_lat", lat, 8);
    op8(8'h80, 8'h7F, 1'b1, pw, lat);
    check("w8_m128x127", pw, 16'hC080);
    op8(8'hFF, 8'hFF, 1'b0, pw, lat);
    check("w8_255x255", pw, 16'hFE01);
    op8(8'h00, 8'h9C, 1'b1, pw, lat);
    check("w8_zero", pw, 16'h0000);
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = 8'($urandom_range(255));
        rb = 8'($urandom_range(255));
        op8(ra, rb, m[0], pw, lat);
        check(m[0] ? "w8_sweep_signed" : "w8_sweep_unsigned", pw, ref8(ra, rb, m[0]));
        check("w8_sweep_lat", lat, 8);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
